// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_ctrl
// Description : sysclk-domain command sequencer behind a byte-level SPI slave.
//               Synchronises CS and byte-ready, frames bytes into read/write
//               commands on a bank of 8-bit control registers and feeds read
//               replies back to the slave tx path.
//               Optional watchdog: define SPI_REG_CTRL_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl #(
  parameter int         NUM_REGS    = 8,
  parameter int         ADDR_W      = 3,
  parameter logic [7:0] REG_RST     = 8'h00,
  parameter int         WDOG_CYCLES = 12_000_000
) (
  input  logic                  sysclk,
  input  logic                  nreset,
  input  logic                  spi_cs_i,
  input  logic                  rx_ready_i,
  input  logic [7:0]            rx_data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_ready_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_strobe_o,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic                  err_o,
  output logic                  wdog_o
);

  localparam logic [2:0] c_StIdle  = 3'd0;
  localparam logic [2:0] c_StCmd   = 3'd1;
  localparam logic [2:0] c_StWdata = 3'd2;
  localparam logic [2:0] c_StRdata = 3'd3;
  localparam logic [2:0] c_StErr   = 3'd4;

  localparam logic [7:0]        c_NumRegs  = 8'(NUM_REGS);
  localparam logic [ADDR_W-1:0] c_LastAddr = ADDR_W'(NUM_REGS - 1);

  // Reject configurations the address logic cannot represent
  generate
    if (NUM_REGS < 1 || NUM_REGS > 128 || (1 << ADDR_W) < NUM_REGS || WDOG_CYCLES < 2) begin : g_badParams
      $error("spi_reg_ctrl: illegal parameter combination");
    end
  endgenerate

  logic [1:0]        r_csSync;
  logic              r_csPrev;
  logic [1:0]        r_rxSync;
  logic              r_rxPrev;
  logic              r_byteStb;
  logic [2:0]        r_state;
  logic [2:0]        w_stateNext;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_nextAddr;
  logic              r_reload;
  logic [7:0]        r_regs [NUM_REGS];

  logic w_csFall, w_csRise;
  logic w_cmdRead, w_cmdBad;
  logic [ADDR_W-1:0] w_cmdAddr;
  logic w_setAddr, w_loadRead, w_errPulse, w_commitWr, w_advRead;
  logic w_wdogFire;

  // Double-flop CS and byte-ready into sysclk; keep a delayed copy for edge detection
  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      r_csSync  <= 2'b11;
      r_csPrev  <= 1'b1;
      r_rxSync  <= 2'b00;
      r_rxPrev  <= 1'b0;
      r_byteStb <= 1'b0;
    end else begin
      r_csSync  <= {r_csSync[0], spi_cs_i};
      r_csPrev  <= r_csSync[1];
      r_rxSync  <= {r_rxSync[0], rx_ready_i};
      r_rxPrev  <= r_rxSync[1];
      r_byteStb <= r_rxSync[1] & ~r_rxPrev;
    end
  end

  assign w_csFall   = r_csPrev & ~r_csSync[1];
  assign w_csRise   = ~r_csPrev & r_csSync[1];
  assign w_cmdRead  = rx_data_i[7];
  assign w_cmdBad   = ({1'b0, rx_data_i[6:0]} >= c_NumRegs);
  assign w_cmdAddr  = rx_data_i[ADDR_W-1:0];
  assign w_nextAddr = (r_addr == c_LastAddr) ? '0 : r_addr + ADDR_W'(1);

  // FSM state register
  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) r_state <= c_StIdle;
    else         r_state <= w_stateNext;
  end

  // FSM next-state: CS rise always returns to IDLE, bytes steer the command phase
  always_comb begin
    w_stateNext = r_state;
    if (w_csRise) begin
      w_stateNext = c_StIdle;
    end else begin
      case (r_state)
        c_StIdle: if (w_csFall) w_stateNext = c_StCmd;
        c_StCmd: begin
          if (r_byteStb) begin
            if (w_cmdBad)       w_stateNext = c_StErr;
            else if (w_cmdRead) w_stateNext = c_StRdata;
            else                w_stateNext = c_StWdata;
          end
        end
        c_StWdata, c_StRdata, c_StErr: w_stateNext = r_state;
        default: w_stateNext = c_StIdle;
      endcase
    end
  end

  // FSM outputs: per-byte datapath actions, suppressed in the CS-rise cycle
  always_comb begin
    w_setAddr  = 1'b0;
    w_loadRead = 1'b0;
    w_errPulse = 1'b0;
    w_commitWr = 1'b0;
    w_advRead  = 1'b0;
    if (!w_csRise && r_byteStb) begin
      case (r_state)
        c_StCmd: begin
          if (w_cmdBad) begin
            w_errPulse = 1'b1;
          end else begin
            w_setAddr  = 1'b1;
            w_loadRead = w_cmdRead;
          end
        end
        c_StWdata: w_commitWr = 1'b1;
        c_StRdata: w_advRead  = 1'b1;
        default: ;
      endcase
    end
  end

  // Address pointer, reply byte and event pulses; a read byte drops txReady for
  // one cycle before the next register is presented
  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      r_addr      <= '0;
      r_reload    <= 1'b0;
      tx_data_o   <= 8'h00;
      tx_ready_o  <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      wr_strobe_o <= w_commitWr;
      err_o       <= w_errPulse;
      r_reload    <= 1'b0;
      if (w_commitWr) wr_addr_o <= r_addr;
      if (w_csRise) begin
        tx_ready_o <= 1'b0;
        r_addr     <= '0;
      end else if (w_setAddr) begin
        r_addr <= w_cmdAddr;
        if (w_loadRead) begin
          tx_data_o  <= r_regs[w_cmdAddr];
          tx_ready_o <= 1'b1;
        end
      end else if (w_commitWr) begin
        r_addr <= w_nextAddr;
      end else if (w_advRead) begin
        tx_ready_o <= 1'b0;
        r_addr     <= w_nextAddr;
        r_reload   <= 1'b1;
      end else if (r_reload && r_state == c_StRdata) begin
        tx_data_o  <= r_regs[r_addr];
        tx_ready_o <= 1'b1;
      end
    end
  end

  // Register bank: watchdog restore loses to a write committing in the same cycle
  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_RST;
    end else if (w_wdogFire) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_RST;
    end else if (w_commitWr) begin
      r_regs[r_addr] <= rx_data_i;
    end
  end

  generate
    for (genvar n = 0; n < NUM_REGS; n++) begin : g_regOut
      assign regs_o[8*n +: 8] = r_regs[n];
    end
  endgenerate

`ifdef SPI_REG_CTRL_WDOG_EN
  localparam int                c_WdogW    = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [c_WdogW-1:0] c_WdogLast = c_WdogW'(WDOG_CYCLES - 1);

  logic [c_WdogW-1:0] r_wdogCnt;

  assign w_wdogFire = (r_wdogCnt == c_WdogLast) && !w_commitWr;

  // Inactivity counter, cleared by every committed write or by its own timeout
  always_ff @(posedge sysclk or negedge nreset) begin
    if (!nreset) begin
      r_wdogCnt <= '0;
      wdog_o    <= 1'b0;
    end else begin
      wdog_o <= w_wdogFire;
      if (w_commitWr || w_wdogFire) r_wdogCnt <= '0;
      else                          r_wdogCnt <= r_wdogCnt + c_WdogW'(1);
    end
  end
`else
  assign w_wdogFire = 1'b0;
  assign wdog_o     = 1'b0;
`endif

endmodule
`default_nettype wire
